// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single WMFC-style RAM port.
// One transaction at a time: IDLE -> ACCESS (wait for MFC or timeout) -> RESP (ack pulse).
module mem_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_rnw,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_err,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_rnw,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic          dma_err,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_enable,
   output logic          mem_rnw,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          MFC,
   output logic          busy,
   output logic          owner
);

   localparam logic [3:0] TMO = 4'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state_q, state_d;
   logic            grant, grant_dma;
   logic            owner_q;
   logic            lat_rnw;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_wdata;
   logic [3:0]      wait_cnt;
   logic            err_q;
   logic [DW-1:0]   cpu_rdata_q, dma_rdata_q;

   // On a tie the requester that was not served last wins; owner resets to DMA so CPU wins first.
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      grant_dma = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req || dma_req) begin
               grant     = 1'b1;
               grant_dma = dma_req && (!cpu_req || !owner_q);
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (MFC || (wait_cnt == TMO)) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b1;
         lat_rnw     <= 1'b1;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         wait_cnt    <= '0;
         err_q       <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q   <= grant_dma;
            lat_rnw   <= grant_dma ? dma_rnw   : cpu_rnw;
            lat_addr  <= grant_dma ? dma_addr  : cpu_addr;
            lat_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            wait_cnt  <= '0;
         end
         // MFC is checked before the timeout compare so it wins a same-cycle race.
         if (state_q == ACCESS) begin
            if (MFC) begin
               err_q <= 1'b0;
               if (lat_rnw) begin
                  if (owner_q) dma_rdata_q <= mem_rdata;
                  else         cpu_rdata_q <= mem_rdata;
               end
            end else if (wait_cnt == TMO) begin
               err_q <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 4'd1;
            end
         end
      end
   end

   assign mem_enable = (state_q == ACCESS);
   assign busy       = (state_q != IDLE);
   assign mem_rnw    = lat_rnw;
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign owner      = owner_q;
   assign cpu_ack    = (state_q == RESP) && !owner_q;
   assign dma_ack    = (state_q == RESP) &&  owner_q;
   assign cpu_err    = cpu_ack && err_q;
   assign dma_err    = dma_ack && err_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, reads/writes, round-robin, timeout, reset abort, dropped req.
module tb_mem_arbiter;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       cpu_req = 1'b0, cpu_rnw = 1'b1;
   logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
   logic       cpu_ack, cpu_err;
   logic [7:0] cpu_rdata;
   logic       dma_req = 1'b0, dma_rnw = 1'b1;
   logic [7:0] dma_addr = 8'h00, dma_wdata = 8'h00;
   logic       dma_ack, dma_err;
   logic [7:0] dma_rdata;
   logic       mem_enable, mem_rnw;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
   logic       MFC = 1'b0;
   logic       busy, owner;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
      .CLK(CLK), .reset(reset),
      .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
      .mem_enable(mem_enable), .mem_rnw(mem_rnw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .MFC(MFC), .busy(busy), .owner(owner)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         done;
      int         steps;
      int         en_cycles;
      int         cpu_acks;
      int         dma_acks;
      int         both_acks;
      int         unstable;
      logic       rnw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       err;
      logic       ack_owner;
   } txn_t;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Plays the RAM side until an ack appears: MFC on enable cycle mfc_at (-1 = never).
   task automatic run_txn(input int mfc_at, input logic [7:0] rd, input int drop_cpu_at, output txn_t r);
      r = '{done: 0, steps: 0, en_cycles: 0, cpu_acks: 0, dma_acks: 0, both_acks: 0,
            unstable: 0, rnw: 1'b0, addr: 8'h00, wdata: 8'h00, err: 1'b0, ack_owner: 1'b0};
      for (int c = 0; c < 40; c++) begin
         if (mem_enable) begin
            if (r.en_cycles == 0) begin
               r.rnw = mem_rnw; r.addr = mem_addr; r.wdata = mem_wdata;
            end else if (mem_rnw !== r.rnw || mem_addr !== r.addr || mem_wdata !== r.wdata) begin
               r.unstable++;
            end
            MFC = (r.en_cycles == mfc_at);
            mem_rdata = MFC ? rd : 8'hEE;
            r.en_cycles++;
         end else begin
            MFC = 1'b0;
         end
         if (drop_cpu_at == c) cpu_req = 1'b0;
         step();
         r.steps++;
         if (cpu_ack && dma_ack) r.both_acks++;
         if (cpu_ack) begin r.cpu_acks++; r.err = cpu_err; r.ack_owner = owner; end
         if (dma_ack) begin r.dma_acks++; r.err = dma_err; r.ack_owner = owner; end
         if (cpu_ack || dma_ack) begin r.done = 1; break; end
      end
      MFC = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      MFC = 1'b1;
      cpu_req = 1'b1;
      dma_req = 1'b1;
      reset = 1'b1;
      step();
      step();
      checks++; if (mem_enable !== 1'b0) begin failures++; $display("FAIL rst_mem_enable got=%0h exp=0", mem_enable); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      MFC = 1'b0;
      reset = 1'b0;
      checks++; if (mem_rnw !== 1'b1) begin failures++; $display("FAIL rst_mem_rnw got=%0h exp=1", mem_rnw); end
      checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=00", mem_addr); end
      checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL rst_mem_wdata got=%0h exp=00", mem_wdata); end
      checks++; if (owner !== 1'b1) begin failures++; $display("FAIL rst_owner got=%0h exp=1", owner); end
      checks++; if ({cpu_ack, dma_ack, cpu_err, dma_err} !== 4'b0000) begin failures++; $display("FAIL rst_ack_err got=%b exp=0000", {cpu_ack, dma_ack, cpu_err, dma_err}); end
      checks++; if (cpu_rdata !== 8'h00 || dma_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=00/00", cpu_rdata, dma_rdata); end
   endtask

   task automatic test_idle_mfc();
      MFC = 1'b1;
      mem_rdata = 8'hA5;
      step();
      step();
      MFC = 1'b0;
      checks++; if (busy !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin failures++; $display("FAIL idle_mfc busy/acks got=%b%b%b exp=000", busy, cpu_ack, dma_ack); end
      checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL idle_mfc_rdata got=%h exp=00", cpu_rdata); end
   endtask

   task automatic test_cpu_read();
      txn_t r;
      cpu_rnw = 1'b1; cpu_addr = 8'h12; cpu_wdata = 8'h00; cpu_req = 1'b1;
      run_txn(2, 8'h5A, -1, r);
      cpu_req = 1'b0;
      checks++; if (r.done !== 1) begin failures++; $display("FAIL rd_done got=%0d exp=1", r.done); end
      checks++; if (r.addr !== 8'h12 || r.rnw !== 1'b1) begin failures++; $display("FAIL rd_mem_addr_rnw got=%h/%b exp=12/1", r.addr, r.rnw); end
      checks++; if (r.en_cycles !== 3 || r.steps !== 4) begin failures++; $display("FAIL rd_latency en=%0d steps=%0d exp=3/4", r.en_cycles, r.steps); end
      checks++; if (r.cpu_acks !== 1 || r.dma_acks !== 0) begin failures++; $display("FAIL rd_acks got=%0d/%0d exp=1/0", r.cpu_acks, r.dma_acks); end
      checks++; if (cpu_rdata !== 8'h5A || r.err !== 1'b0) begin failures++; $display("FAIL rd_data_err got=%h/%b exp=5a/0", cpu_rdata, r.err); end
      checks++; if (dma_rdata !== 8'h00 || r.unstable !== 0) begin failures++; $display("FAIL rd_dma_stable got=%h/%0d exp=00/0", dma_rdata, r.unstable); end
      step();
      checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rd_after ack=%b busy=%b exp=0/0", cpu_ack, busy); end
   endtask

   task automatic test_round_robin();
      txn_t r1, r2, r3;
      do_reset();
      cpu_rnw = 1'b1; cpu_addr = 8'h21;
      dma_rnw = 1'b0; dma_addr = 8'h44; dma_wdata = 8'h99;
      cpu_req = 1'b1; dma_req = 1'b1;
      run_txn(0, 8'h11, -1, r1);
      cpu_addr = 8'h22;
      checks++; if (r1.cpu_acks !== 1 || r1.ack_owner !== 1'b0 || r1.steps !== 2) begin failures++; $display("FAIL rr_first acks=%0d owner=%b steps=%0d exp=1/0/2", r1.cpu_acks, r1.ack_owner, r1.steps); end
      checks++; if (cpu_rdata !== 8'h11 || r1.addr !== 8'h21) begin failures++; $display("FAIL rr_first_data got=%h/%h exp=11/21", cpu_rdata, r1.addr); end
      run_txn(1, 8'h77, -1, r2);
      dma_req = 1'b0;
      checks++; if (r2.dma_acks !== 1 || r2.cpu_acks !== 0 || r2.ack_owner !== 1'b1) begin failures++; $display("FAIL rr_second acks=%0d/%0d owner=%b exp=0/1/1", r2.cpu_acks, r2.dma_acks, r2.ack_owner); end
      checks++; if (r2.addr !== 8'h44 || r2.rnw !== 1'b0 || r2.wdata !== 8'h99) begin failures++; $display("FAIL rr_second_mem got=%h/%b/%h exp=44/0/99", r2.addr, r2.rnw, r2.wdata); end
      checks++; if (cpu_rdata !== 8'h11 || dma_rdata !== 8'h00) begin failures++; $display("FAIL rr_second_rdata got=%h/%h exp=11/00", cpu_rdata, dma_rdata); end
      run_txn(0, 8'h33, -1, r3);
      cpu_req = 1'b0;
      checks++; if (r3.cpu_acks !== 1 || r3.ack_owner !== 1'b0 || r3.addr !== 8'h22) begin failures++; $display("FAIL rr_third acks=%0d owner=%b addr=%h exp=1/0/22", r3.cpu_acks, r3.ack_owner, r3.addr); end
      checks++; if (r1.both_acks + r2.both_acks + r3.both_acks !== 0) begin failures++; $display("FAIL rr_both_acks got=%0d exp=0", r1.both_acks + r2.both_acks + r3.both_acks); end
      step();
   endtask

   task automatic test_timeout();
      txn_t r;
      logic [7:0] dma_rd_before;
      dma_rd_before = dma_rdata;
      dma_rnw = 1'b0; dma_addr = 8'h80; dma_wdata = 8'hC3; dma_req = 1'b1;
      run_txn(-1, 8'h00, -1, r);
      dma_req = 1'b0;
      checks++; if (r.en_cycles !== 16) begin failures++; $display("FAIL to_en_cycles got=%0d exp=16", r.en_cycles); end
      checks++; if (r.dma_acks !== 1 || r.err !== 1'b1 || r.cpu_acks !== 0) begin failures++; $display("FAIL to_ack_err acks=%0d err=%b cpu=%0d exp=1/1/0", r.dma_acks, r.err, r.cpu_acks); end
      checks++; if (r.addr !== 8'h80 || r.wdata !== 8'hC3 || r.rnw !== 1'b0) begin failures++; $display("FAIL to_mem got=%h/%h/%b exp=80/c3/0", r.addr, r.wdata, r.rnw); end
      checks++; if (dma_rdata !== dma_rd_before) begin failures++; $display("FAIL to_rdata got=%h exp=%h", dma_rdata, dma_rd_before); end
      step();
      checks++; if (busy !== 1'b0 || dma_ack !== 1'b0 || dma_err !== 1'b0) begin failures++; $display("FAIL to_idle busy=%b ack=%b err=%b exp=000", busy, dma_ack, dma_err); end
   endtask

   task automatic test_mfc_at_limit();
      txn_t r;
      dma_rnw = 1'b1; dma_addr = 8'h90; dma_req = 1'b1;
      run_txn(15, 8'hB6, -1, r);
      dma_req = 1'b0;
      checks++; if (r.en_cycles !== 16 || r.dma_acks !== 1) begin failures++; $display("FAIL lim_cycles en=%0d acks=%0d exp=16/1", r.en_cycles, r.dma_acks); end
      checks++; if (r.err !== 1'b0 || dma_rdata !== 8'hB6) begin failures++; $display("FAIL lim_err_data got=%b/%h exp=0/b6", r.err, dma_rdata); end
      step();
   endtask

   task automatic test_reset_abort();
      txn_t r;
      cpu_rnw = 1'b1; cpu_addr = 8'h30; cpu_req = 1'b1;
      step();
      step();
      checks++; if (mem_enable !== 1'b1 || mem_addr !== 8'h30) begin failures++; $display("FAIL abort_access en=%b addr=%h exp=1/30", mem_enable, mem_addr); end
      reset = 1'b1; cpu_req = 1'b0; MFC = 1'b1; mem_rdata = 8'h55;
      step();
      reset = 1'b0; MFC = 1'b0;
      checks++; if (mem_enable !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin failures++; $display("FAIL abort_state en=%b busy=%b ack=%b exp=000", mem_enable, busy, cpu_ack); end
      step();
      checks++; if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00) begin failures++; $display("FAIL abort_noack ack=%b rdata=%h exp=0/00", cpu_ack, cpu_rdata); end
      cpu_addr = 8'h31; cpu_req = 1'b1;
      run_txn(1, 8'h7E, -1, r);
      cpu_req = 1'b0;
      checks++; if (r.cpu_acks !== 1 || cpu_rdata !== 8'h7E || r.err !== 1'b0 || r.addr !== 8'h31) begin failures++; $display("FAIL abort_fresh acks=%0d rdata=%h err=%b addr=%h exp=1/7e/0/31", r.cpu_acks, cpu_rdata, r.err, r.addr); end
      step();
   endtask

   task automatic test_dropped_req();
      txn_t r;
      cpu_rnw = 1'b1; cpu_addr = 8'h40; cpu_req = 1'b1;
      run_txn(3, 8'hD2, 1, r);
      checks++; if (r.cpu_acks !== 1 || r.en_cycles !== 4 || cpu_rdata !== 8'hD2) begin failures++; $display("FAIL drop_complete acks=%0d en=%0d rdata=%h exp=1/4/d2", r.cpu_acks, r.en_cycles, cpu_rdata); end
      checks++; if (r.addr !== 8'h40 || r.unstable !== 0) begin failures++; $display("FAIL drop_mem addr=%h unstable=%0d exp=40/0", r.addr, r.unstable); end
      step();
      step();
      checks++; if (cpu_ack !== 1'b0 || busy !== 1'b0 || mem_enable !== 1'b0) begin failures++; $display("FAIL drop_once ack=%b busy=%b en=%b exp=000", cpu_ack, busy, mem_enable); end
   endtask

   initial begin
      test_reset();
      test_idle_mfc();
      test_cpu_read();
      test_round_robin();
      test_timeout();
      test_mfc_at_limit();
      test_reset_abort();
      test_dropped_req();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
